std_mem_d2_rr_arbiter: RTL

//  Round-robin arbiter that shares one 2-D std_mem_d2 instance between NREQ go/done requesters.

---
 rtl/std_mem_arb_pkg.sv | 20 ++
 rtl/std_mem_d2_rr_arbiter_rr_pick.sv | 33 +++
 rtl/std_mem_d2_rr_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/std_mem_arb_pkg.sv
// Shared types and helpers for the std_mem_d2 round-robin arbiter.
package std_mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        WR      = 3'd2,
        WR_WAIT = 3'd3,
        RESP    = 3'd4
    } arb_state_e;

    // Index width for NREQ requesters; never less than 1 bit.
    function automatic int clog2_nreq(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/std_mem_d2_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod NREQ.
module rr_pick
    import std_mem_arb_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IW = clog2_nreq(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
            cand = sum[IW-1:0];
            if (!any && req[cand]) begin
                any       = 1'b1;
                grant_idx = cand;
            end
        end
    end

endmodule

// File: rtl/std_mem_d2_rr_arbiter.sv
// Round-robin arbiter sharing one std_mem_d2 between NREQ go/done requesters.
module std_mem_d2_rr_arbiter
    import std_mem_arb_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int D0_SIZE     = 16,
    parameter int D1_SIZE     = 16,
    parameter int D0_IDX_SIZE = 4,
    parameter int D1_IDX_SIZE = 4,
    parameter int NREQ        = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_go,
    input  logic [NREQ-1:0]             req_write_en,
    input  logic [NREQ*D0_IDX_SIZE-1:0] req_addr0,
    input  logic [NREQ*D1_IDX_SIZE-1:0] req_addr1,
    input  logic [NREQ*WIDTH-1:0]       req_write_data,
    output logic [NREQ-1:0]             req_done,
    output logic                        req_oob,
    output logic [WIDTH-1:0]            read_data,
    output logic [D0_IDX_SIZE-1:0]      mem_addr0,
    output logic [D1_IDX_SIZE-1:0]      mem_addr1,
    output logic [WIDTH-1:0]            mem_write_data,
    output logic                        mem_write_en,
    input  logic [WIDTH-1:0]            mem_read_data,
    input  logic                        mem_done
);

    localparam int IW = clog2_nreq(NREQ);

    arb_state_e state, state_nxt;

    logic [IW-1:0]          rr_ptr, idx, pick_idx;
    logic                   pick_any;
    logic                   lat_we, lat_oob;
    logic [D0_IDX_SIZE-1:0] lat_a0, sel_a0;
    logic [D1_IDX_SIZE-1:0] lat_a1, sel_a1;
    logic [WIDTH-1:0]       lat_wd, sel_wd;
    logic                   sel_we, sel_oob;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req       (req_go),
        .ptr       (rr_ptr),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    assign sel_a0  = req_addr0[pick_idx*D0_IDX_SIZE +: D0_IDX_SIZE];
    assign sel_a1  = req_addr1[pick_idx*D1_IDX_SIZE +: D1_IDX_SIZE];
    assign sel_wd  = req_write_data[pick_idx*WIDTH +: WIDTH];
    assign sel_we  = req_write_en[pick_idx];
    assign sel_oob = (32'(sel_a0) >= 32'(D0_SIZE)) || (32'(sel_a1) >= 32'(D1_SIZE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            idx       <= '0;
            lat_we    <= 1'b0;
            lat_oob   <= 1'b0;
            lat_a0    <= '0;
            lat_a1    <= '0;
            lat_wd    <= '0;
            read_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_any) begin
                idx     <= pick_idx;
                lat_we  <= sel_we;
                lat_oob <= sel_oob;
                lat_a0  <= sel_a0;
                lat_a1  <= sel_a1;
                lat_wd  <= sel_wd;
            end
            if (state == RD) read_data <= mem_read_data;
            if (state == RESP) rr_ptr <= (idx == IW'(NREQ-1)) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        req_done       = '0;
        req_oob        = 1'b0;
        mem_addr0      = '0;
        mem_addr1      = '0;
        mem_write_data = '0;
        mem_write_en   = 1'b0;
        // The memory sees the latched request in every state except IDLE.
        if (state != IDLE) begin
            mem_addr0      = lat_a0;
            mem_addr1      = lat_a1;
            mem_write_data = lat_wd;
        end
        case (state)
            IDLE: begin
                if (pick_any) begin
                    if (sel_oob)     state_nxt = RESP;
                    else if (sel_we) state_nxt = WR;
                    else             state_nxt = RD;
                end
            end
            RD:      state_nxt = RESP;
            WR: begin
                mem_write_en = 1'b1;
                state_nxt    = WR_WAIT;
            end
            WR_WAIT: if (mem_done) state_nxt = RESP;
            RESP: begin
                req_done[idx] = 1'b1;
                req_oob       = lat_oob;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
